// File: rtl/deser_pkg.sv
// Shared constants for the 8-lane deserializer.
`timescale 1ns/1ps
package deser_pkg;
  localparam int unsigned DESER_LANES = 8;
  localparam int unsigned DESER_SLOT_W = 3;
  localparam logic [DESER_SLOT_W-1:0] DESER_LAST_SLOT = 3'd7;
endpackage

// File: rtl/dec3_8.sv
// 3-to-8 one-hot decoder with enable; the receive-side mirror of the 8:1 mux select.
`timescale 1ns/1ps
module dec3_8
  import deser_pkg::*;
(
  input  logic [DESER_SLOT_W-1:0] i_sel,
  input  logic                    i_en,
  output logic [DESER_LANES-1:0]  o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_sel] = 1'b1;
    end
  end

endmodule

// File: rtl/deser8_demux.sv
// Serial-to-parallel deserializer: 8 W-bit beats assembled into one valid/ready word.
// Define DESER_PARITY_EN to add the registered even-parity output out_par.
`timescale 1ns/1ps
module deser8_demux
  import deser_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [W-1:0]              in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DESER_LANES*W-1:0]  out_data,
  output logic [DESER_SLOT_W-1:0]   slot
`ifdef DESER_PARITY_EN
  ,
  output logic                      out_par
`endif
);

  localparam int unsigned AsmW = (DESER_LANES - 1) * W;

  logic [DESER_SLOT_W-1:0]  r_slot;
  logic [AsmW-1:0]          r_asm;
  logic [DESER_LANES*W-1:0] r_out_data;
  logic                     r_out_valid;
  logic                     w_accept;
  logic [DESER_LANES-1:0]   w_lane_we;
  logic                     w_done;

  // Only the completing beat can stall; earlier lanes of the next word flow in.
  assign in_ready  = ~((r_slot == DESER_LAST_SLOT) & r_out_valid & ~out_ready);
  assign w_accept  = in_valid & in_ready & ~flush;
  assign w_done    = w_lane_we[DESER_LANES-1];
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign slot      = r_slot;

  dec3_8 u_dec (
    .i_sel    (r_slot),
    .i_en     (w_accept),
    .o_onehot (w_lane_we)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= '0;
    end else if (flush) begin
      r_slot <= '0;
    end else if (w_accept) begin
      r_slot <= r_slot + 1'b1;
    end
  end

  // Lane 7 is never stored: it goes straight into the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_asm <= '0;
    end else begin
      for (int unsigned k = 0; k < DESER_LANES - 1; k++) begin
        if (w_lane_we[k]) begin
          r_asm[k*W +: W] <= in_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_done) begin
      r_out_data  <= {in_data, r_asm};
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef DESER_PARITY_EN
  logic r_out_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_par <= 1'b0;
    end else if (w_done) begin
      r_out_par <= ^{in_data, r_asm};
    end
  end

  assign out_par = r_out_par;
`endif

endmodule

// File: tb/tb_deser8_demux.sv
// Self-checking bench: W=1 and W=4 instances driven in lockstep, checked against a queue scoreboard.
`timescale 1ns/1ps
module tb_deser8_demux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_data = '0;
  logic        out_ready = 1'b1;

  logic        in_ready1, in_ready4;
  logic        out_valid1, out_valid4;
  logic [7:0]  out_data1;
  logic [31:0] out_data4;
  logic [2:0]  slot1, slot4;
`ifdef DESER_PARITY_EN
  logic        out_par1, out_par4;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  deser8_demux #(.W(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .in_data   (in_data[0]),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_data  (out_data1),
    .slot      (slot1)
`ifdef DESER_PARITY_EN
    ,
    .out_par   (out_par1)
`endif
  );

  deser8_demux #(.W(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .in_data   (in_data),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .out_data  (out_data4),
    .slot      (slot4)
`ifdef DESER_PARITY_EN
    ,
    .out_par   (out_par4)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lane_bit0(input logic [31:0] w);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = w[k*4];
    return r;
  endfunction

  // Reference model: slot, assembly lanes, output-valid and the expected-word queue.
  logic [2:0]  m_slot;
  logic [31:0] m_asm;
  logic        m_ov;
  logic [31:0] sb_q[$];
  logic        m_in_ready, m_acc, m_done;

  assign m_in_ready = !(m_slot == 3'd7 && m_ov && !out_ready);
  assign m_acc      = in_valid && m_in_ready && !flush;
  assign m_done     = m_acc && (m_slot == 3'd7);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_slot <= '0;
      m_asm  <= '0;
      m_ov   <= 1'b0;
      sb_q.delete();
    end else begin
      if (flush) m_slot <= '0;
      else if (m_acc) m_slot <= m_slot + 3'd1;
      if (m_acc) m_asm[m_slot*4 +: 4] <= in_data;
      if (m_done) begin
        sb_q.push_back({in_data, m_asm[27:0]});
        m_ov <= 1'b1;
      end else if (out_ready) begin
        m_ov <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("slot4", 32'(slot4), 32'(m_slot));
      check_eq("slot1", 32'(slot1), 32'(m_slot));
      check_eq("in_ready4", 32'(in_ready4), 32'(m_in_ready));
      check_eq("in_ready1", 32'(in_ready1), 32'(m_in_ready));
      check_eq("out_valid4", 32'(out_valid4), 32'(m_ov));
      check_eq("out_valid1", 32'(out_valid1), 32'(m_ov));
      if (out_valid4) begin
        check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          check_eq("word4", out_data4, sb_q[0]);
          check_eq("word1", 32'(out_data1), 32'(lane_bit0(sb_q[0])));
`ifdef DESER_PARITY_EN
          check_eq("par4", 32'(out_par4), 32'(^sb_q[0]));
          check_eq("par1", 32'(out_par1), 32'(^lane_bit0(sb_q[0])));
`endif
          if (out_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  // Offer one beat until accepted (bounded), optionally idle a cycle afterwards.
  task automatic send(input logic [3:0] d, input bit gap);
    int  n = 0;
    bit  acc;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      acc = in_ready4;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) check_eq("accept_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0]  pat;
  logic [31:0] held;

  initial begin
    pat = 8'b0100_1101;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_slot", 32'(slot4), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid4), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready4), 32'd1);
    check_eq("rst_out_data4", out_data4, 32'd0);
    check_eq("rst_out_data1", 32'(out_data1), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Dense word: beats 1,0,1,1,0,0,1,0 on bit 0.
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) send({3'($urandom), pat[k]}, 1'b0);
    check_eq("dense_valid", 32'(out_valid1), 32'd1);
    check_eq("dense_word1", 32'(out_data1), 32'h4d);
`ifdef DESER_PARITY_EN
    check_eq("dense_par1", 32'(out_par1), 32'd0);
`endif
    idle(2);

    // Backpressure: 15 beats with the consumer stalled, then the 16th on release.
    out_ready = 1'b0;
    for (int k = 0; k < 15; k++) send(4'($urandom), 1'b0);
    check_eq("bp_stall_ready", 32'(in_ready4), 32'd0);
    check_eq("bp_stall_slot", 32'(slot4), 32'd7);
    held = out_data4;
    in_valid = 1'b1;
    in_data  = 4'($urandom);
    idle(3);
    check_eq("bp_hold_data", out_data4, held);
    check_eq("bp_hold_slot", 32'(slot4), 32'd7);
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(in_ready4), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("bp_no_bubble", 32'(out_valid4), 32'd1);
    check_eq("bp_slot_wrap", 32'(slot4), 32'd0);
    idle(3);

    // Gappy input gives the same word as the dense case.
    for (int k = 0; k < 8; k++) send({3'($urandom), pat[k]}, k < 7);
    check_eq("gap_valid", 32'(out_valid1), 32'd1);
    check_eq("gap_word1", 32'(out_data1), 32'h4d);
    idle(2);

    // Flush with a beat offered while a word is pending.
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) send(4'($urandom), 1'b0);
    held = out_data4;
    for (int k = 0; k < 3; k++) send(4'($urandom), 1'b0);
    in_valid = 1'b1;
    in_data  = 4'($urandom);
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("flush_slot", 32'(slot4), 32'd0);
    check_eq("flush_pending", 32'(out_valid4), 32'd1);
    check_eq("flush_data", out_data4, held);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) send(4'($urandom), 1'b0);
    idle(3);

    // Asynchronous reset at slot 5 with a word pending.
    out_ready = 1'b0;
    for (int k = 0; k < 13; k++) send(4'($urandom), 1'b0);
    check_eq("pre_rst_slot", 32'(slot4), 32'd5);
    check_eq("pre_rst_valid", 32'(out_valid4), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_slot", 32'(slot4), 32'd0);
    check_eq("arst_valid4", 32'(out_valid4), 32'd0);
    check_eq("arst_valid1", 32'(out_valid1), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(1);
    check_eq("post_rst_idle", 32'(out_valid4), 32'd0);
    for (int k = 0; k < 8; k++) send(4'($urandom), 1'b0);
    check_eq("post_rst_valid", 32'(out_valid4), 32'd1);
    idle(3);
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
